// File: rtl/sprite_compositor.sv
// Two-stage sprite/wall compositor for the VGA pixel stream, with frame-driven
// mouth animation, frightened-ghost blink and death fade-out.
module sprite_compositor #(
  parameter int unsigned NUM_SPRITES  = 4,
  parameter int unsigned SPRITE_W     = 8,
  parameter int unsigned COORD_W      = 10,
  parameter int unsigned ANIM_FRAMES  = 8,
  parameter int unsigned BLINK_FRAMES = 16
) (
  input  logic                                   Clk,
  input  logic                                   Reset,
  input  logic                                   frame_start,
  input  logic                                   pixel_valid,
  input  logic [COORD_W-1:0]                     DrawX,
  input  logic [COORD_W-1:0]                     DrawY,
  input  logic [NUM_SPRITES*COORD_W-1:0]         sprite_x,
  input  logic [NUM_SPRITES*COORD_W-1:0]         sprite_y,
  input  logic [NUM_SPRITES-1:0]                 sprite_en,
  input  logic [NUM_SPRITES-1:0]                 sprite_flip_x,
  input  logic [NUM_SPRITES-1:0]                 sprite_frightened,
  input  logic                                   frightened_ending,
  input  logic [NUM_SPRITES*24-1:0]              sprite_color,
  input  logic [NUM_SPRITES*SPRITE_W*SPRITE_W-1:0] sprite_bitmap,
  input  logic [SPRITE_W*SPRITE_W-1:0]           pac_closed_bitmap,
  input  logic                                   pac_moving,
  input  logic                                   wall_on,
  input  logic                                   death,
  output logic [7:0]                             Red,
  output logic [7:0]                             Green,
  output logic [7:0]                             Blue,
  output logic                                   out_valid,
  output logic                                   fade_done
);

  localparam int unsigned IDX_W    = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
  localparam int unsigned BM_W     = SPRITE_W * SPRITE_W;
  localparam int unsigned BM_IDX_W = (BM_W > 1) ? $clog2(BM_W) : 1;
  localparam int unsigned ANIM_W   = $clog2(ANIM_FRAMES + 1);
  localparam int unsigned BLINK_W  = $clog2(BLINK_FRAMES + 1);

  // frame-driven state
  logic [ANIM_W-1:0]  anim_cnt_q, anim_cnt_d;
  logic               mouth_closed_q, mouth_closed_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_phase_q, blink_phase_d;
  logic [3:0]         fade_level_q, fade_level_d;
  logic               fade_done_q, fade_done_d;

  // stage 1
  logic                                s1_valid_q, s1_valid_d;
  logic [NUM_SPRITES-1:0]              s1_hit_q, s1_hit_d;
  logic [NUM_SPRITES-1:0][IDX_W-1:0]   s1_dx_q, s1_dx_d;
  logic [NUM_SPRITES-1:0][IDX_W-1:0]   s1_dy_q, s1_dy_d;
  logic                                s1_wall_q, s1_wall_d;
  logic                                s1_mouth_q, s1_mouth_d;
  logic                                s1_blink_q, s1_blink_d;
  logic [3:0]                          s1_fade_q, s1_fade_d;

  // stage 2 / output
  logic [23:0] rgb_q, rgb_d;
  logic        out_valid_q, out_valid_d;

  logic [NUM_SPRITES-1:0][COORD_W-1:0] dx_full, dy_full;
  logic [COORD_W-1:0]                  sx, sy;

  always_comb begin
    anim_cnt_d     = anim_cnt_q;
    mouth_closed_d = mouth_closed_q;
    if (frame_start && pac_moving) begin
      if (anim_cnt_q == ANIM_W'(ANIM_FRAMES - 1)) begin
        anim_cnt_d     = '0;
        mouth_closed_d = ~mouth_closed_q;
      end else begin
        anim_cnt_d = anim_cnt_q + ANIM_W'(1);
      end
    end

    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (!frightened_ending) begin
      blink_cnt_d   = '0;
      blink_phase_d = 1'b0;
    end else if (frame_start) begin
      if (blink_cnt_q == BLINK_W'(BLINK_FRAMES - 1)) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
      end
    end

    fade_level_d = fade_level_q;
    if (!death) begin
      fade_level_d = '0;
    end else if (frame_start && fade_level_q != 4'd8) begin
      fade_level_d = fade_level_q + 4'd1;
    end
    fade_done_d = (fade_level_d == 4'd8);
  end

  // Frame state is snapshotted alongside the pixel so a pixel that coincides
  // with frame_start is composited with the pre-update values.
  always_comb begin
    dx_full  = '0;
    dy_full  = '0;
    sx       = '0;
    sy       = '0;
    s1_hit_d = '0;
    s1_dx_d  = '0;
    s1_dy_d  = '0;
    for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
      sx          = sprite_x[i*COORD_W +: COORD_W];
      sy          = sprite_y[i*COORD_W +: COORD_W];
      dx_full[i]  = DrawX - sx;
      dy_full[i]  = DrawY - sy;
      s1_hit_d[i] = sprite_en[i] && (DrawX >= sx) && (DrawY >= sy) &&
                    (dx_full[i] < COORD_W'(SPRITE_W)) &&
                    (dy_full[i] < COORD_W'(SPRITE_W));
      s1_dx_d[i]  = dx_full[i][IDX_W-1:0];
      s1_dy_d[i]  = dy_full[i][IDX_W-1:0];
    end
    s1_valid_d = pixel_valid;
    s1_wall_d  = wall_on;
    s1_mouth_d = mouth_closed_q;
    s1_blink_d = blink_phase_q;
    s1_fade_d  = fade_level_q;
  end

  logic [BM_W-1:0]     bm;
  logic [IDX_W-1:0]    col;
  logic [BM_IDX_W-1:0] bit_idx;
  logic                bit_on;
  logic                found;
  logic [23:0]         pix_rgb;
  logic [23:0]         faded;

  always_comb begin
    bm      = '0;
    col     = '0;
    bit_idx = '0;
    bit_on  = 1'b0;
    found   = 1'b0;
    pix_rgb = '0;
    for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
      bm      = (i == 0 && s1_mouth_q) ? pac_closed_bitmap : sprite_bitmap[i*BM_W +: BM_W];
      col     = sprite_flip_x[i] ? (IDX_W'(SPRITE_W - 1) - s1_dx_q[i]) : s1_dx_q[i];
      bit_idx = BM_IDX_W'(32'(s1_dy_q[i]) * SPRITE_W + (SPRITE_W - 1) - 32'(col));
      bit_on  = bm[bit_idx];
      if (!found && s1_hit_q[i] && bit_on) begin
        found = 1'b1;
        if (i != 0 && sprite_frightened[i]) begin
          pix_rgb = (frightened_ending && s1_blink_q) ? 24'hFFFFFF : 24'h2121FF;
        end else begin
          pix_rgb = sprite_color[i*24 +: 24];
        end
      end
    end
    if (s1_wall_q) begin
      pix_rgb = 24'h0000FF;
    end
    faded       = {pix_rgb[23:16] >> s1_fade_q, pix_rgb[15:8] >> s1_fade_q,
                   pix_rgb[7:0] >> s1_fade_q};
    rgb_d       = s1_valid_q ? faded : rgb_q;
    out_valid_d = s1_valid_q;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      anim_cnt_q     <= '0;
      mouth_closed_q <= 1'b0;
      blink_cnt_q    <= '0;
      blink_phase_q  <= 1'b0;
      fade_level_q   <= '0;
      fade_done_q    <= 1'b0;
      s1_valid_q     <= 1'b0;
      s1_hit_q       <= '0;
      s1_dx_q        <= '0;
      s1_dy_q        <= '0;
      s1_wall_q      <= 1'b0;
      s1_mouth_q     <= 1'b0;
      s1_blink_q     <= 1'b0;
      s1_fade_q      <= '0;
      rgb_q          <= '0;
      out_valid_q    <= 1'b0;
    end else begin
      anim_cnt_q     <= anim_cnt_d;
      mouth_closed_q <= mouth_closed_d;
      blink_cnt_q    <= blink_cnt_d;
      blink_phase_q  <= blink_phase_d;
      fade_level_q   <= fade_level_d;
      fade_done_q    <= fade_done_d;
      s1_valid_q     <= s1_valid_d;
      s1_hit_q       <= s1_hit_d;
      s1_dx_q        <= s1_dx_d;
      s1_dy_q        <= s1_dy_d;
      s1_wall_q      <= s1_wall_d;
      s1_mouth_q     <= s1_mouth_d;
      s1_blink_q     <= s1_blink_d;
      s1_fade_q      <= s1_fade_d;
      rgb_q          <= rgb_d;
      out_valid_q    <= out_valid_d;
    end
  end

  assign Red       = rgb_q[23:16];
  assign Green     = rgb_q[15:8];
  assign Blue      = rgb_q[7:0];
  assign out_valid = out_valid_q;
  assign fade_done = fade_done_q;

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor: priority, clipping, flip, mouth
// animation, frightened blink, fade and pipelining.
module tb_sprite_compositor;

  logic         clk = 1'b0;
  logic         Reset, frame_start, pixel_valid;
  logic [9:0]   DrawX, DrawY;
  logic [39:0]  sprite_x, sprite_y;
  logic [3:0]   sprite_en, sprite_flip_x, sprite_frightened;
  logic         frightened_ending;
  logic [95:0]  sprite_color;
  logic [255:0] sprite_bitmap;
  logic [63:0]  pac_closed_bitmap;
  logic         pac_moving, wall_on, death;
  logic [7:0]   Red, Green, Blue;
  logic         out_valid, fade_done;

  int vectors = 0;
  int miscompares = 0;

  sprite_compositor #(
    .NUM_SPRITES(4), .SPRITE_W(8), .COORD_W(10), .ANIM_FRAMES(8), .BLINK_FRAMES(16)
  ) dut (
    .Clk(clk), .Reset(Reset), .frame_start(frame_start), .pixel_valid(pixel_valid),
    .DrawX(DrawX), .DrawY(DrawY), .sprite_x(sprite_x), .sprite_y(sprite_y),
    .sprite_en(sprite_en), .sprite_flip_x(sprite_flip_x),
    .sprite_frightened(sprite_frightened), .frightened_ending(frightened_ending),
    .sprite_color(sprite_color), .sprite_bitmap(sprite_bitmap),
    .pac_closed_bitmap(pac_closed_bitmap), .pac_moving(pac_moving), .wall_on(wall_on),
    .death(death), .Red(Red), .Green(Green), .Blue(Blue), .out_valid(out_valid),
    .fade_done(fade_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic place(input int i, input int x, input int y);
    sprite_x[i*10 +: 10] = 10'(x);
    sprite_y[i*10 +: 10] = 10'(y);
  endtask

  task automatic set_row0(input int i, input logic [7:0] val);
    sprite_bitmap[i*64 +: 8] = val;
  endtask

  // Presents one pixel and returns what appears two cycles later.
  task automatic pix(input int x, input int y, input logic w,
                     output logic v, output logic [23:0] rgb);
    pixel_valid = 1'b1;
    DrawX = 10'(x);
    DrawY = 10'(y);
    wall_on = w;
    @(negedge clk);
    pixel_valid = 1'b0;
    wall_on = 1'b0;
    @(negedge clk);
    v = out_valid;
    rgb = {Red, Green, Blue};
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({out_valid, Red, Green, Blue, fade_done} !== 26'd0) begin
      miscompares++;
      $display("FAIL reset: got v=%0b rgb=%02h%02h%02h done=%0b, want all 0",
               out_valid, Red, Green, Blue, fade_done);
    end
    Reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    logic v;
    logic [23:0] rgb;
    place(0, 100, 50);
    sprite_en = 4'b0001;
    set_row0(0, 8'h80);
    sprite_color[23:0] = 24'hFFFF00;
    pix(100, 50, 1'b0, v, rgb);
    vectors++;
    if ({v, rgb} !== {1'b1, 24'hFFFF00}) begin
      miscompares++;
      $display("FAIL basic_hit: got v=%0b rgb=%06h, want v=1 rgb=FFFF00", v, rgb);
    end
    pix(101, 50, 1'b0, v, rgb);
    vectors++;
    if ({v, rgb} !== {1'b1, 24'h000000}) begin
      miscompares++;
      $display("FAIL basic_transparent: got v=%0b rgb=%06h, want v=1 rgb=000000", v, rgb);
    end
    pix(100, 50, 1'b0, v, rgb);
    // Mid-stream reset: the in-flight pixel must vanish.
    pixel_valid = 1'b1;
    DrawX = 10'd100;
    DrawY = 10'd50;
    @(negedge clk);
    Reset = 1'b1;
    @(negedge clk);
    pixel_valid = 1'b0;
    vectors++;
    if ({out_valid, Red, Green, Blue} !== 25'd0) begin
      miscompares++;
      $display("FAIL reset_mid: got v=%0b rgb=%02h%02h%02h, want v=0 rgb=000000",
               out_valid, Red, Green, Blue);
    end
    Reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_discard: got v=%0b, want v=0", out_valid);
    end
  endtask

  task automatic test_priority;
    logic v;
    logic [23:0] rgb;
    place(0, 20, 20);
    place(1, 20, 20);
    sprite_en = 4'b0011;
    set_row0(1, 8'h80);
    sprite_color[47:24] = 24'hFF0000;
    pix(20, 20, 1'b0, v, rgb);
    vectors++;
    if ({v, rgb} !== {1'b1, 24'hFFFF00}) begin
      miscompares++;
      $display("FAIL prio_sprite0: got v=%0b rgb=%06h, want v=1 rgb=FFFF00", v, rgb);
    end
    set_row0(0, 8'h00);
    pix(20, 20, 1'b0, v, rgb);
    vectors++;
    if ({v, rgb} !== {1'b1, 24'hFF0000}) begin
      miscompares++;
      $display("FAIL prio_fallthrough: got v=%0b rgb=%06h, want v=1 rgb=FF0000", v, rgb);
    end
    pix(20, 20, 1'b1, v, rgb);
    vectors++;
    if ({v, rgb} !== {1'b1, 24'h0000FF}) begin
      miscompares++;
      $display("FAIL prio_wall: got v=%0b rgb=%06h, want v=1 rgb=0000FF", v, rgb);
    end
    sprite_en = 4'b0001;
    pix(20, 20, 1'b0, v, rgb);
    vectors++;
    if ({v, rgb} !== {1'b1, 24'h000000}) begin
      miscompares++;
      $display("FAIL prio_disabled: got v=%0b rgb=%06h, want v=1 rgb=000000", v, rgb);
    end
  endtask

  task automatic test_clip_flip;
    logic v;
    logic [23:0] rgb;
    sprite_en = 4'b0001;
    set_row0(0, 8'hFF);
    place(0, 1020, 0);
    pix(3, 0, 1'b0, v, rgb);
    vectors++;
    if ({v, rgb} !== {1'b1, 24'h000000}) begin
      miscompares++;
      $display("FAIL clip_nowrap: got v=%0b rgb=%06h, want v=1 rgb=000000", v, rgb);
    end
    pix(1023, 0, 1'b0, v, rgb);
    vectors++;
    if ({v, rgb} !== {1'b1, 24'hFFFF00}) begin
      miscompares++;
      $display("FAIL clip_edge_hit: got v=%0b rgb=%06h, want v=1 rgb=FFFF00", v, rgb);
    end
    place(0, 500, 0);
    pix(507, 0, 1'b0, v, rgb);
    vectors++;
    if ({v, rgb} !== {1'b1, 24'hFFFF00}) begin
      miscompares++;
      $display("FAIL clip_x7: got v=%0b rgb=%06h, want v=1 rgb=FFFF00", v, rgb);
    end
    pix(508, 0, 1'b0, v, rgb);
    vectors++;
    if ({v, rgb} !== {1'b1, 24'h000000}) begin
      miscompares++;
      $display("FAIL clip_x8: got v=%0b rgb=%06h, want v=1 rgb=000000", v, rgb);
    end
    set_row0(0, 8'h80);
    sprite_flip_x = 4'b0001;
    pix(507, 0, 1'b0, v, rgb);
    vectors++;
    if ({v, rgb} !== {1'b1, 24'hFFFF00}) begin
      miscompares++;
      $display("FAIL flip_right: got v=%0b rgb=%06h, want v=1 rgb=FFFF00", v, rgb);
    end
    pix(500, 0, 1'b0, v, rgb);
    vectors++;
    if ({v, rgb} !== {1'b1, 24'h000000}) begin
      miscompares++;
      $display("FAIL flip_left: got v=%0b rgb=%06h, want v=1 rgb=000000", v, rgb);
    end
    sprite_flip_x = 4'b0000;
  endtask

  task automatic test_mouth;
    logic v;
    logic [23:0] rgb;
    place(0, 200, 100);
    set_row0(0, 8'h80);
    pac_closed_bitmap[7:0] = 8'h40;
    pac_moving = 1'b1;
    frames(7);
    pix(200, 100, 1'b0, v, rgb);
    vectors++;
    if ({v, rgb} !== {1'b1, 24'hFFFF00}) begin
      miscompares++;
      $display("FAIL mouth_open_7: got v=%0b rgb=%06h, want v=1 rgb=FFFF00", v, rgb);
    end
    frames(1);
    pix(200, 100, 1'b0, v, rgb);
    vectors++;
    if ({v, rgb} !== {1'b1, 24'h000000}) begin
      miscompares++;
      $display("FAIL mouth_closed_col0: got v=%0b rgb=%06h, want v=1 rgb=000000", v, rgb);
    end
    pix(201, 100, 1'b0, v, rgb);
    vectors++;
    if ({v, rgb} !== {1'b1, 24'hFFFF00}) begin
      miscompares++;
      $display("FAIL mouth_closed_col1: got v=%0b rgb=%06h, want v=1 rgb=FFFF00", v, rgb);
    end
    pac_moving = 1'b0;
    frames(20);
    pix(201, 100, 1'b0, v, rgb);
    vectors++;
    if ({v, rgb} !== {1'b1, 24'hFFFF00}) begin
      miscompares++;
      $display("FAIL mouth_hold: got v=%0b rgb=%06h, want v=1 rgb=FFFF00", v, rgb);
    end
  endtask

  task automatic test_blink;
    logic v;
    logic [23:0] rgb;
    place(0, 0, 400);
    pac_closed_bitmap[7:0] = 8'h80;
    place(1, 300, 200);
    sprite_en = 4'b0011;
    set_row0(1, 8'h80);
    sprite_frightened = 4'b0011;
    frightened_ending = 1'b1;
    pix(0, 400, 1'b0, v, rgb);
    vectors++;
    if ({v, rgb} !== {1'b1, 24'hFFFF00}) begin
      miscompares++;
      $display("FAIL pac_not_frightened: got v=%0b rgb=%06h, want v=1 rgb=FFFF00", v, rgb);
    end
    frames(15);
    pix(300, 200, 1'b0, v, rgb);
    vectors++;
    if ({v, rgb} !== {1'b1, 24'h2121FF}) begin
      miscompares++;
      $display("FAIL blink_blue_15: got v=%0b rgb=%06h, want v=1 rgb=2121FF", v, rgb);
    end
    frames(1);
    pix(300, 200, 1'b0, v, rgb);
    vectors++;
    if ({v, rgb} !== {1'b1, 24'hFFFFFF}) begin
      miscompares++;
      $display("FAIL blink_white_16: got v=%0b rgb=%06h, want v=1 rgb=FFFFFF", v, rgb);
    end
    frames(15);
    pix(300, 200, 1'b0, v, rgb);
    vectors++;
    if ({v, rgb} !== {1'b1, 24'hFFFFFF}) begin
      miscompares++;
      $display("FAIL blink_white_31: got v=%0b rgb=%06h, want v=1 rgb=FFFFFF", v, rgb);
    end
    frames(1);
    pix(300, 200, 1'b0, v, rgb);
    vectors++;
    if ({v, rgb} !== {1'b1, 24'h2121FF}) begin
      miscompares++;
      $display("FAIL blink_blue_32: got v=%0b rgb=%06h, want v=1 rgb=2121FF", v, rgb);
    end
    frames(16);
    frightened_ending = 1'b0;
    frames(1);
    pix(300, 200, 1'b0, v, rgb);
    vectors++;
    if ({v, rgb} !== {1'b1, 24'h2121FF}) begin
      miscompares++;
      $display("FAIL blink_drop: got v=%0b rgb=%06h, want v=1 rgb=2121FF", v, rgb);
    end
    frightened_ending = 1'b1;
    frames(1);
    pix(300, 200, 1'b0, v, rgb);
    vectors++;
    if ({v, rgb} !== {1'b1, 24'h2121FF}) begin
      miscompares++;
      $display("FAIL blink_restart: got v=%0b rgb=%06h, want v=1 rgb=2121FF", v, rgb);
    end
    frightened_ending = 1'b0;
    sprite_frightened = 4'b0000;
    pix(300, 200, 1'b0, v, rgb);
    vectors++;
    if ({v, rgb} !== {1'b1, 24'hFF0000}) begin
      miscompares++;
      $display("FAIL ghost_normal: got v=%0b rgb=%06h, want v=1 rgb=FF0000", v, rgb);
    end
  endtask

  task automatic test_fade;
    logic v;
    logic [23:0] rgb;
    place(0, 200, 100);
    sprite_en = 4'b0001;
    sprite_color[23:0] = 24'hFF8040;
    death = 1'b1;
    pix(200, 100, 1'b0, v, rgb);
    vectors++;
    if ({v, rgb} !== {1'b1, 24'hFF8040}) begin
      miscompares++;
      $display("FAIL fade_0: got v=%0b rgb=%06h, want v=1 rgb=FF8040", v, rgb);
    end
    frames(1);
    pix(200, 100, 1'b0, v, rgb);
    vectors++;
    if ({v, rgb} !== {1'b1, 24'h7F4020}) begin
      miscompares++;
      $display("FAIL fade_1: got v=%0b rgb=%06h, want v=1 rgb=7F4020", v, rgb);
    end
    frames(6);
    pix(200, 100, 1'b0, v, rgb);
    vectors++;
    if ({v, rgb, fade_done} !== {1'b1, 24'h010100, 1'b0}) begin
      miscompares++;
      $display("FAIL fade_7: got v=%0b rgb=%06h done=%0b, want v=1 rgb=010100 done=0",
               v, rgb, fade_done);
    end
    frames(1);
    vectors++;
    if (fade_done !== 1'b1) begin
      miscompares++;
      $display("FAIL fade_done_8: got %0b, want 1", fade_done);
    end
    frames(2);
    pix(200, 100, 1'b0, v, rgb);
    vectors++;
    if ({v, rgb, fade_done} !== {1'b1, 24'h000000, 1'b1}) begin
      miscompares++;
      $display("FAIL fade_sat: got v=%0b rgb=%06h done=%0b, want v=1 rgb=000000 done=1",
               v, rgb, fade_done);
    end
    death = 1'b0;
    @(negedge clk);
    pix(200, 100, 1'b0, v, rgb);
    vectors++;
    if ({v, rgb, fade_done} !== {1'b1, 24'hFF8040, 1'b0}) begin
      miscompares++;
      $display("FAIL fade_clear: got v=%0b rgb=%06h done=%0b, want v=1 rgb=FF8040 done=0",
               v, rgb, fade_done);
    end
  endtask

  task automatic test_back_to_back;
    logic [23:0] exp_rgb [3];
    exp_rgb[0] = 24'hFF8040;
    exp_rgb[1] = 24'h000000;
    exp_rgb[2] = 24'hFF8040;
    set_row0(0, 8'hA0);
    pac_closed_bitmap[7:0] = 8'hA0;
    for (int i = 0; i < 5; i++) begin
      pixel_valid = (i < 3);
      DrawX = 10'(200 + i);
      DrawY = 10'd100;
      @(negedge clk);
      if (i >= 1 && i <= 3) begin
        vectors++;
        if ({out_valid, Red, Green, Blue} !== {1'b1, exp_rgb[i-1]}) begin
          miscompares++;
          $display("FAIL b2b_%0d: got v=%0b rgb=%02h%02h%02h, want v=1 rgb=%06h",
                   i - 1, out_valid, Red, Green, Blue, exp_rgb[i-1]);
        end
      end
    end
    vectors++;
    if ({out_valid, Red, Green, Blue} !== {1'b0, 24'hFF8040}) begin
      miscompares++;
      $display("FAIL b2b_hold: got v=%0b rgb=%02h%02h%02h, want v=0 rgb=FF8040",
               out_valid, Red, Green, Blue);
    end
  endtask

  initial begin
    Reset = 1'b1;
    frame_start = 1'b0;
    pixel_valid = 1'b0;
    DrawX = '0;
    DrawY = '0;
    sprite_x = '0;
    sprite_y = '0;
    sprite_en = '0;
    sprite_flip_x = '0;
    sprite_frightened = '0;
    frightened_ending = 1'b0;
    sprite_color = '0;
    sprite_bitmap = '0;
    pac_closed_bitmap = '0;
    pac_moving = 1'b0;
    wall_on = 1'b0;
    death = 1'b0;
    @(negedge clk);
    test_reset;
    test_basic;
    test_priority;
    test_clip_flip;
    test_mouth;
    test_blink;
    test_fade;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
